systolic_edge_feeder: RTL

Upstream feeder for the N×N systolic multiply array. It buffers one A matrix and one B matrix, loaded row by row over a valid/ready stream. On `start` it drives the array's left edge (A rows) and top edge (B columns) with the diagonal skew the processing elements require. It also generates the array-wide `feed_en` for the full fill-and-flush window and pulses `done` when the window closes.

---
 rtl/systolic_edge_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for the NxN systolic array: buffers one A and one B matrix and
// replays them with the per-lane diagonal skew, then flushes with zero lanes.
module systolic_edge_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sel,
  input  logic [RW-1:0]   in_row,
  input  logic [N*DW-1:0] in_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            feed_en,
  output logic [N*DW-1:0] a_feed,
  output logic [N*DW-1:0] b_feed
);

  localparam int TW = $clog2(3 * N - 1);
  localparam logic [TW-1:0] LAST_STEP = TW'(3 * N - 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_t;
  logic [DW-1:0]     r_a [N][N];
  logic [DW-1:0]     r_b [N][N];
  logic              r_busy;
  logic              r_done;
  logic              r_feed_en;
  logic [N*DW-1:0]   r_a_feed;
  logic [N*DW-1:0]   r_b_feed;

  logic [TW-1:0]     w_step;
  logic [N*DW-1:0]   w_a_next;
  logic [N*DW-1:0]   w_b_next;
  logic              w_accept;

  assign in_ready = reset_n && (r_state == S_IDLE) && !start;
  assign w_accept = in_valid && in_ready;

  assign busy    = r_busy;
  assign done    = r_done;
  assign feed_en = r_feed_en;
  assign a_feed  = r_a_feed;
  assign b_feed  = r_b_feed;

  // Lanes for the step being registered this edge: step 0 on the start edge,
  // otherwise the successor of the step currently on the outputs.
  always_comb begin
    w_step   = (r_state == S_FEED) ? (r_t + TW'(1)) : '0;
    w_a_next = '0;
    w_b_next = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (i + k == int'(w_step)) begin
          w_a_next[i*DW +: DW] = r_a[i][k];
          w_b_next[i*DW +: DW] = r_b[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_t       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_feed_en <= 1'b0;
      r_a_feed  <= '0;
      r_b_feed  <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FEED;
            r_t       <= '0;
            r_busy    <= 1'b1;
            r_feed_en <= 1'b1;
            r_a_feed  <= w_a_next;
            r_b_feed  <= w_b_next;
          end else if (w_accept) begin
            // Rows beyond N-1 match no bank row and are silently dropped.
            for (int r = 0; r < N; r++) begin
              if (in_row == RW'(r)) begin
                for (int c = 0; c < N; c++) begin
                  if (in_sel) r_b[r][c] <= in_data[c*DW +: DW];
                  else        r_a[r][c] <= in_data[c*DW +: DW];
                end
              end
            end
          end
        end
        S_FEED: begin
          if (r_t == LAST_STEP) begin
            r_state   <= S_DONE;
            r_feed_en <= 1'b0;
            r_done    <= 1'b1;
            r_a_feed  <= '0;
            r_b_feed  <= '0;
          end else begin
            r_t      <= r_t + TW'(1);
            r_a_feed <= w_a_next;
            r_b_feed <= w_b_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_t     <= '0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_t       <= '0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_feed_en <= 1'b0;
          r_a_feed  <= '0;
          r_b_feed  <= '0;
        end
      endcase
    end
  end

endmodule
